nec_ir_module: RTL and testbench



---
 rtl/nec_ir_module.sv | 228 ++++++++++++++++++++++
 tb/tb_nec_ir_module.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_module.sv
// NEC infrared remote decoder: synchronizes the receiver output, times each
// mark/space with a saturating counter and validates address/command bytes.
//
// state      | meaning
// IDLE       | line idle, waiting for the leader mark falling edge
// LEAD_MARK  | timing the leader mark
// LEAD_SPACE | timing the leader space (data frame or repeat code)
// BIT_MARK   | timing a data bit mark
// BIT_SPACE  | timing a data bit space; its length decides the bit value
// STOP       | waiting for the stop mark (or repeat burst) to end
module nec_ir_module #(
    parameter int multiplier    = 1,
    parameter int divider       = 1,
    parameter int counter_width = 16,
    parameter int address_width = 8,
    parameter int data_width    = 8
) (
    output logic [address_width-1:0] ir_address,
    output logic [data_width-1:0]    ir_data,
    output logic                     ir_data_ready,
    output logic                     ir_error,
    input  logic                     ir_in,
    input  logic                     reset_n,
    input  logic                     clk
);

    localparam int FRAME_BITS = 2 * (address_width + data_width);
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    typedef logic [counter_width-1:0] cnt_t;

    function automatic cnt_t scale(input int us);
        return cnt_t'(us * multiplier / divider);
    endfunction

    localparam cnt_t LEAD_MARK_MIN  = scale(8000);
    localparam cnt_t LEAD_MARK_MAX  = scale(10000);
    localparam cnt_t LEAD_DATA_MIN  = scale(4000);
    localparam cnt_t LEAD_DATA_MAX  = scale(5000);
    localparam cnt_t LEAD_RPT_MIN   = scale(2000);
    localparam cnt_t LEAD_RPT_MAX   = scale(2500);
    localparam cnt_t BIT_MARK_MIN   = scale(400);
    localparam cnt_t BIT_MARK_MAX   = scale(750);
    localparam cnt_t BIT_ZERO_MIN   = scale(400);
    localparam cnt_t BIT_ZERO_MAX   = scale(750);
    localparam cnt_t BIT_ONE_MIN    = scale(1400);
    localparam cnt_t BIT_ONE_MAX    = scale(1900);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    function automatic logic in_win(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP
    } state_t;

    state_t state, state_nxt;

    logic ir_meta, ir_sync, ir_prev;
    logic edge_rise, edge_fall;
    cnt_t count;

    logic [FRAME_BITS-1:0] shift_reg, shift_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    logic err_nxt, shift_en, bit_val, clr_bits, check_en, frame_ok;

    logic [address_width-1:0] addr_f, addr_inv_f;
    logic [data_width-1:0]    cmd_f, cmd_inv_f;

    // Receiver output is asynchronous; idle level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_meta <= 1'b1;
            ir_sync <= 1'b1;
            ir_prev <= 1'b1;
        end else begin
            ir_meta <= ir_in;
            ir_sync <= ir_meta;
            ir_prev <= ir_sync;
        end
    end

    assign edge_rise = ir_sync & ~ir_prev;
    assign edge_fall = ~ir_sync & ir_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (edge_rise || edge_fall) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        shift_en  = 1'b0;
        bit_val   = 1'b0;
        clr_bits  = 1'b0;
        check_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_fall) begin
                    state_nxt = S_LEAD_MARK;
                end
            end
            // Bad leader marks are treated as noise: no error pulse.
            S_LEAD_MARK: begin
                if (edge_rise) begin
                    state_nxt = in_win(count, LEAD_MARK_MIN, LEAD_MARK_MAX) ? S_LEAD_SPACE : S_IDLE;
                end else if (count > LEAD_MARK_MAX) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LEAD_SPACE: begin
                if (edge_fall) begin
                    if (in_win(count, LEAD_DATA_MIN, LEAD_DATA_MAX)) begin
                        state_nxt = S_BIT_MARK;
                        clr_bits  = 1'b1;
                    end else if (in_win(count, LEAD_RPT_MIN, LEAD_RPT_MAX)) begin
                        state_nxt = S_STOP;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (count > LEAD_DATA_MAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_BIT_MARK: begin
                if (edge_rise) begin
                    if (in_win(count, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state_nxt = S_BIT_SPACE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (count > BIT_MARK_MAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_BIT_SPACE: begin
                if (edge_fall) begin
                    if (in_win(count, BIT_ZERO_MIN, BIT_ZERO_MAX) ||
                        in_win(count, BIT_ONE_MIN, BIT_ONE_MAX)) begin
                        shift_en = 1'b1;
                        bit_val  = in_win(count, BIT_ONE_MIN, BIT_ONE_MAX);
                        if (bit_cnt == LAST_BIT) begin
                            check_en  = 1'b1;
                            state_nxt = S_STOP;
                        end else begin
                            state_nxt = S_BIT_MARK;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (count > BIT_ONE_MAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_STOP: begin
                if (ir_sync) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // LSB-first reception: new bits enter at the top and walk down.
    assign shift_nxt  = {bit_val, shift_reg[FRAME_BITS-1:1]};
    assign addr_f     = shift_nxt[address_width-1:0];
    assign addr_inv_f = shift_nxt[2*address_width-1:address_width];
    assign cmd_f      = shift_nxt[2*address_width+data_width-1:2*address_width];
    assign cmd_inv_f  = shift_nxt[FRAME_BITS-1:2*address_width+data_width];
    assign frame_ok   = (addr_inv_f == ~addr_f) && (cmd_inv_f == ~cmd_f);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg     <= '0;
            bit_cnt       <= '0;
            ir_address    <= '0;
            ir_data       <= '0;
            ir_data_ready <= 1'b0;
            ir_error      <= 1'b0;
        end else begin
            ir_data_ready <= check_en & frame_ok;
            ir_error      <= err_nxt | (check_en & ~frame_ok);
            if (clr_bits) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (shift_en) begin
                shift_reg <= shift_nxt;
            end
            if (check_en && frame_ok) begin
                ir_address <= addr_f;
                ir_data    <= cmd_f;
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_module.sv
// Bench for nec_ir_module: drives NEC waveforms on ir_in, predicts each pulse
// from the frame contents and checks it in an independent monitor.
`timescale 1ns/1ps
module tb_nec_ir_module;

    localparam int MUL = 1;
    localparam int DIV = 20;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int ONE_MAX_T = 1900 * MUL / DIV;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ir_in = 1'b1;
    logic [AW-1:0] ir_address;
    logic [DW-1:0] ir_data;
    logic          ir_data_ready;
    logic          ir_error;

    nec_ir_module #(
        .multiplier(MUL),
        .divider(DIV),
        .counter_width(16),
        .address_width(AW),
        .data_width(DW)
    ) dut (
        .ir_address(ir_address),
        .ir_data(ir_data),
        .ir_data_ready(ir_data_ready),
        .ir_error(ir_error),
        .ir_in(ir_in),
        .reset_n(reset_n),
        .clk(clk)
    );

    always #500 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          is_err;
        logic [AW-1:0] addr;
        logic [DW-1:0] cmd;
        int            lo;
        int            hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [AW-1:0] model_addr = '0;
    logic [DW-1:0] model_cmd  = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (reset_n) begin
            while (sb.size() > 0 && cyc > sb[0].hi) begin
                check("pulse_missing_by_cycle", cyc, sb[0].hi);
                sb.delete(0);
            end
            if (ir_data_ready || ir_error) begin
                check("pulse_exclusive", ir_data_ready && ir_error, 0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {ir_data_ready, ir_error}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_is_error", ir_error, mon_e.is_err);
                    check("pulse_cycle", (cyc >= mon_e.lo && cyc <= mon_e.hi) ? mon_e.lo : cyc, mon_e.lo);
                    check("ir_address", ir_address, mon_e.addr);
                    check("ir_data", ir_data, mon_e.cmd);
                end
            end
        end
    end

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int dur(input int us, input int jit);
        int base;
        int sgn;
        base = us * MUL / DIV;
        sgn  = ($urandom_range(0, 1) == 1) ? 1 : -1;
        return base * (100 + sgn * jit) / 100;
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    task automatic hold(input logic lvl, input int n);
        ir_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Reference: the frame is good iff each inverse byte is the complement.
    task automatic expect_frame(input logic [31:0] bits);
        exp_t e;
        logic ok;
        ok = (bits[15:8] == ~bits[7:0]) && (bits[31:24] == ~bits[23:16]);
        if (ok) begin
            model_addr = bits[7:0];
            model_cmd  = bits[23:16];
        end
        e.is_err = !ok;
        e.addr   = model_addr;
        e.cmd    = model_cmd;
        e.lo     = cyc + 3;
        e.hi     = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic send_leader(input int jit);
        hold(1'b0, dur(9000, jit));
        hold(1'b1, dur(4500, jit));
    endtask

    task automatic send_bit(input logic b, input int jit);
        hold(1'b0, dur(560, jit));
        hold(1'b1, b ? dur(1690, jit) : dur(560, jit));
    endtask

    task automatic send_frame(input logic [31:0] bits, input int jit);
        send_leader(jit);
        for (int i = 0; i < 32; i++) send_bit(bits[i], jit);
        expect_frame(bits);
        hold(1'b0, dur(560, jit));
        hold(1'b1, 100);
    endtask

    task automatic send_repeat();
        hold(1'b0, dur(9000, 0));
        hold(1'b1, dur(2250, 0));
        hold(1'b0, dur(560, 0));
        hold(1'b1, 200);
    endtask

    task automatic send_space_timeout();
        exp_t e;
        send_leader(0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
        hold(1'b0, dur(560, 0));
        e.is_err = 1'b1;
        e.addr   = model_addr;
        e.cmd    = model_cmd;
        e.lo     = cyc + ONE_MAX_T + 3;
        e.hi     = cyc + ONE_MAX_T + 6;
        sb.push_back(e);
        hold(1'b1, dur(6000, 0));
        hold(1'b1, 100);
    endtask

    task automatic reset_mid_frame(input logic [31:0] bits);
        send_leader(0);
        for (int i = 0; i < 16; i++) send_bit(bits[i], 0);
        hold(1'b0, 10);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ir_address", ir_address, 0);
        check("reset_ir_data", ir_data, 0);
        check("reset_ready", ir_data_ready, 0);
        check("reset_error", ir_error, 0);
        model_addr = '0;
        model_cmd  = '0;
        hold(1'b1, 5);
        reset_n = 1'b1;
        hold(1'b1, 100);
    endtask

    initial begin
        logic [31:0] bits;
        ir_in   = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("init_ir_address", ir_address, 0);
        check("init_ir_data", ir_data, 0);
        check("init_ready", ir_data_ready, 0);
        check("init_error", ir_error, 0);
        reset_n = 1'b1;
        hold(1'b1, 20);

        send_frame(mk(8'h00, 8'h45), 0);
        send_frame({8'hF0, 8'h08, 8'hFB, 8'h04}, 0);

        send_repeat();
        check("repeat_keeps_address", ir_address, model_addr);
        check("repeat_keeps_data", ir_data, model_cmd);

        send_space_timeout();
        send_frame(mk(8'h5A, 8'hC3), 0);

        reset_mid_frame(mk(8'h77, 8'h99));
        send_frame(mk(8'h10, 8'h1C), 0);

        hold(1'b0, dur(200, 0));
        hold(1'b1, 200);
        send_frame(mk(8'h81, 8'h3E), 10);

        for (int k = 0; k < 3; k++) begin
            bits = mk(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) bits[$urandom_range(8, 31)] ^= 1'b1;
            send_frame(bits, int'($urandom_range(0, 8)));
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_ir_address", ir_address, model_addr);
        check("final_ir_data", ir_data, model_cmd);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
